// File: rtl/commit_free_queue_if.sv
// Bundle of signals between ROB retirement, the commit-free queue and the
// rename stage's commit-free port. The queue connects through the slave
// modport. The master modport is the view the ROB/rename side takes.
interface commit_free_queue_if #(
    parameter int N_PHYS   = 64,
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 16
);
    localparam int PW = $clog2(N_PHYS);
    localparam int CW = $clog2(DEPTH + 1);

    logic [COMMIT_W-1:0]         commit_valid_i;
    logic [COMMIT_W-1:0][PW-1:0] commit_preg_i;
    logic                        commit_ready_o;
    logic                        recover_i;
    logic                        free_valid_o;
    logic [PW-1:0]               free_preg_o;
    logic [CW-1:0]               count_o;
    logic                        overflow_o;

    modport slave (
        input  commit_valid_i, commit_preg_i, recover_i,
        output commit_ready_o, free_valid_o, free_preg_o, count_o, overflow_o
    );

    modport master (
        output commit_valid_i, commit_preg_i, recover_i,
        input  commit_ready_o, free_valid_o, free_preg_o, count_o, overflow_o
    );
endinterface

// File: rtl/commit_free_queue.sv
// Commit-free queue. It buffers physical registers that ROB commit releases,
// up to COMMIT_W in each cycle. It hands them to rename's single commit-free
// port at one per cycle. While recovery is active the output is held off,
// because rename's recovery rewrites its free-list tail and would lose a free
// accepted in the same cycle. Queued entries survive recovery.
// p0 releases are discarded. Any release that arrives while ready is low is
// dropped and raises a sticky overflow flag.
module commit_free_queue #(
    parameter int N_PHYS   = 64,
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 16
) (
    input  logic clk,
    input  logic rst,
    commit_free_queue_if.slave bus
);
    localparam int PW = $clog2(N_PHYS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(COMMIT_W + 1);

    logic [PW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       head_q, head_d;
    logic [AW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;

    logic                ready;
    logic                deq;
    logic [COMMIT_W-1:0] live;
    logic [COMMIT_W-1:0] wr_en;
    logic [AW-1:0]       wr_addr [COMMIT_W];
    logic [KW-1:0]       k;

    // Ready depends only on registered occupancy. An in-flight dequeue does
    // not widen the window.
    assign ready = (count_q <= CW'(DEPTH - COMMIT_W));
    assign deq   = (count_q != '0) && !bus.recover_i;

    // Pack the live lanes (valid and not p0) onto consecutive slots starting
    // at tail, in lane order.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        k     = '0;
        live  = '0;
        wr_en = '0;
        for (int l = 0; l < COMMIT_W; l++) begin
            wr_addr[l] = tail_q + AW'(k);
            live[l]    = bus.commit_valid_i[l] && (bus.commit_preg_i[l] != '0);
            if (ready && live[l]) begin
                wr_en[l] = 1'b1;
                k        = k + KW'(1);
            end
        end
    end

    // Compute the next pointer, occupancy and sticky overflow values.
    always_comb begin
        head_d     = head_q + AW'(deq);
        tail_d     = tail_q + AW'(k);
        count_d    = count_q + CW'(k) - CW'(deq);
        overflow_d = overflow_q | (!ready && (|live));
    end

    // Control state. Reset clears it asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array. Each live lane writes its compacted slot.
    // NOTE: the memory has no reset; count gates validity, so clearing it would only cost area and timing.
    always_ff @(posedge clk) begin
        for (int l = 0; l < COMMIT_W; l++) begin
            if (wr_en[l]) begin
                mem_q[wr_addr[l]] <= bus.commit_preg_i[l];
            end
        end
    end

    assign bus.commit_ready_o = ready;
    assign bus.free_valid_o   = deq;
    assign bus.free_preg_o    = mem_q[head_q];
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;

endmodule

// File: tb/tb_commit_free_queue.sv
// Directed bench for commit_free_queue (N_PHYS=64, COMMIT_W=2, DEPTH=16).
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time
// unit later, well away from either clock edge.
module tb_commit_free_queue;
    localparam int N_PHYS   = 64;
    localparam int COMMIT_W = 2;
    localparam int DEPTH    = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    commit_free_queue_if #(.N_PHYS(N_PHYS), .COMMIT_W(COMMIT_W), .DEPTH(DEPTH)) bus ();

    commit_free_queue #(.N_PHYS(N_PHYS), .COMMIT_W(COMMIT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic [1:0] v, input logic [5:0] p0, input logic [5:0] p1,
                         input logic rec);
        bus.commit_valid_i   = v;
        bus.commit_preg_i[0] = p0;
        bus.commit_preg_i[1] = p1;
        bus.recover_i        = rec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL reset_free_valid: got %0b want 0", bus.free_valid_o); end
        checks++; if (bus.commit_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.commit_ready_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow_o); end
        step();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.commit_ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready[%0d]: got %0b want 1", i, bus.commit_ready_o); end
            checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL idle_count[%0d]: got %0d want 0", i, bus.count_o); end
            checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL idle_free_valid[%0d]: got %0b want 0", i, bus.free_valid_o); end
        end
    endtask

    task automatic test_dual_release();
        drive(2'b11, 6'd5, 6'd9, 1'b0);
        #1;
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL dual_no_bypass: got %0b want 0", bus.free_valid_o); end
        step();
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (bus.count_o !== 5'd2) begin errors++; $display("FAIL dual_count_t1: got %0d want 2", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b1) begin errors++; $display("FAIL dual_valid_t1: got %0b want 1", bus.free_valid_o); end
        checks++; if (bus.free_preg_o !== 6'd5) begin errors++; $display("FAIL dual_preg_t1: got %0d want 5", bus.free_preg_o); end
        step();
        checks++; if (bus.free_valid_o !== 1'b1) begin errors++; $display("FAIL dual_valid_t2: got %0b want 1", bus.free_valid_o); end
        checks++; if (bus.free_preg_o !== 6'd9) begin errors++; $display("FAIL dual_preg_t2: got %0d want 9", bus.free_preg_o); end
        step();
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL dual_valid_t3: got %0b want 0", bus.free_valid_o); end
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL dual_count_t3: got %0d want 0", bus.count_o); end
    endtask

    task automatic test_p0_filter();
        drive(2'b11, 6'd0, 6'd7, 1'b0);
        step();
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL p0_count: got %0d want 1", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b1) begin errors++; $display("FAIL p0_valid: got %0b want 1", bus.free_valid_o); end
        checks++; if (bus.free_preg_o !== 6'd7) begin errors++; $display("FAIL p0_preg: got %0d want 7", bus.free_preg_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL p0_overflow: got %0b want 0", bus.overflow_o); end
        step();
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL p0_count_after: got %0d want 0", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL p0_valid_after: got %0b want 0", bus.free_valid_o); end
    endtask

    task automatic test_recovery_hold();
        drive(2'b01, 6'd12, 6'd0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 6'd0, 6'd0, 1'b1);
            #1;
            checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL recover_valid[%0d]: got %0b want 0", i, bus.free_valid_o); end
            checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL recover_count[%0d]: got %0d want 1", i, bus.count_o); end
            step();
        end
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        #1;
        checks++; if (bus.free_valid_o !== 1'b1) begin errors++; $display("FAIL recover_release_valid: got %0b want 1", bus.free_valid_o); end
        checks++; if (bus.free_preg_o !== 6'd12) begin errors++; $display("FAIL recover_release_preg: got %0d want 12", bus.free_preg_o); end
        step();
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL recover_count_after: got %0d want 0", bus.count_o); end
    endtask

    task automatic test_fill_overflow();
        // head/tail start at slot 4 here, so the 16 entries wrap the pointers.
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 6'(20 + 2 * i), 6'(21 + 2 * i), 1'b1);
            #1;
            checks++; if (bus.commit_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %0b want 1", i, bus.commit_ready_o); end
            step();
        end
        drive(2'b00, 6'd0, 6'd0, 1'b1);
        #1;
        checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", bus.count_o); end
        checks++; if (bus.commit_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %0b want 0", bus.commit_ready_o); end
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL fill_valid_held: got %0b want 0", bus.free_valid_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fill_overflow_clear: got %0b want 0", bus.overflow_o); end
        drive(2'b11, 6'd50, 6'd51, 1'b1);
        step();
        drive(2'b00, 6'd0, 6'd0, 1'b1);
        #1;
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b want 1", bus.overflow_o); end
        checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", bus.count_o); end
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            #1;
            checks++; if (bus.free_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %0b want 1", j, bus.free_valid_o); end
            checks++; if (bus.free_preg_o !== 6'(20 + j)) begin errors++; $display("FAIL drain_preg[%0d]: got %0d want %0d", j, bus.free_preg_o, 20 + j); end
            checks++; if (bus.count_o !== 5'(16 - j)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", j, bus.count_o, 16 - j); end
            if (j == 1) begin
                checks++; if (bus.commit_ready_o !== 1'b0) begin errors++; $display("FAIL ready_at_15: got %0b want 0", bus.commit_ready_o); end
            end
            if (j == 2) begin
                checks++; if (bus.commit_ready_o !== 1'b1) begin errors++; $display("FAIL ready_at_14: got %0b want 1", bus.commit_ready_o); end
            end
            step();
        end
        #1;
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid_end: got %0b want 0", bus.free_valid_o); end
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL drain_count_end: got %0d want 0", bus.count_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b want 1", bus.overflow_o); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 6'(40 + 2 * i), 6'(41 + 2 * i), 1'b1);
            step();
        end
        drive(2'b00, 6'd0, 6'd0, 1'b1);
        #1;
        checks++; if (bus.count_o !== 5'd6) begin errors++; $display("FAIL pre_reset_count: got %0d want 6", bus.count_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL async_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid: got %0b want 0", bus.free_valid_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL async_overflow: got %0b want 0", bus.overflow_o); end
        checks++; if (bus.commit_ready_o !== 1'b1) begin errors++; $display("FAIL async_ready: got %0b want 1", bus.commit_ready_o); end
        drive(2'b00, 6'd0, 6'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.free_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %0b want 0", bus.free_valid_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dual_release();
        test_p0_filter();
        test_recovery_hold();
        test_fill_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_free_queue.md
# commit_free_queue

Buffers physical registers released by ROB commit, up to COMMIT_W per cycle, and feeds them to the rename stage's single commit-free port at one per cycle. Sits between ROB retirement and rename. Holds every release while misprediction recovery is asserted, because rename's recovery overwrites its free-list tail and would drop a same-cycle free. Filters out p0 and flags any release the ROB presents without backpressure being honoured.

## Interface
- N_PHYS, 64: physical register count; PW = $clog2(N_PHYS).
- COMMIT_W, 2: commit lanes per cycle (1..4).
- DEPTH, 16: queue entries; power of two, DEPTH >= COMMIT_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- commit_valid_i  in  COMMIT_W  per-lane release valid; lane 0 is oldest.
- commit_preg_i  in  COMMIT_W x PW  per-lane physical register to free.
- commit_ready_o  out  1  high when free slots >= COMMIT_W.
- recover_i  in  1  misprediction recovery, same signal that drives rename.
- free_valid_o  out  1  drives rename rob_commit_free_valid_i.
- free_preg_o  out  PW  drives rename rob_commit_free_preg_i.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- overflow_o  out  1  sticky error flag.

## Operation
- Storage: circular buffer mem[DEPTH] with head and tail pointers, each $clog2(DEPTH) bits, plus count.
- Pointers wrap naturally modulo DEPTH.
- Enqueue happens when commit_ready_o = 1:
  - Valid lanes whose preg != 0 are written at consecutive slots tail, tail+1, ... in lane order.
  - Invalid lanes and p0 lanes are skipped; the written entries are compacted with no holes.
  - tail advances by k, the number written.
- Valid lanes presented while commit_ready_o = 0 are dropped, and overflow_o is set.
  - overflow_o stays set until reset.
  - Lanes carrying p0 are always discarded and never cause overflow.
- Dequeue: free_valid_o = (count != 0) && !recover_i, and free_preg_o = mem[head] (combinational from storage).
  - When free_valid_o = 1, head increments at the clock edge.
  - free_preg_o is don't-care when free_valid_o = 0; it drives mem[head] regardless.
- Recovery does not flush the queue. Committed releases are architecturally final, so they survive a misprediction.
- Count update per cycle: count_next = count + k - (free_valid_o ? 1 : 0). Enqueue and dequeue in the same cycle are legal.
- commit_ready_o = (DEPTH - count) >= COMMIT_W, computed from the registered count.
  - It does not depend on the current cycle's dequeue.
  - It does not combinationally depend on any input.

## Timing
- Reset values while rst = 0: head = tail = count = 0, overflow_o = 0, free_valid_o = 0, count_o = 0, commit_ready_o = 1. mem contents are don't-care.
- Enqueue-to-output latency: an entry written at edge t drives free_valid_o in cycle t+1 at the earliest. There is no same-cycle bypass.
- Throughput: 1 free per cycle out, up to COMMIT_W per cycle in.
- Full boundary: with count = DEPTH - COMMIT_W + 1, commit_ready_o = 0 even if a dequeue is happening that cycle.
- Empty boundary: count = 0 gives free_valid_o = 0. A simultaneous enqueue does not produce output that cycle.
- recover_i held for N cycles stalls dequeue for exactly those N cycles. Enqueue continues during that time.
- Asynchronous reset mid-operation clears the queue immediately; queued releases are lost by design.
- Reset is released synchronously through the standard reset synchronizer upstream; the block assumes rst deassertion is clean relative to clk.

## Test plan
- Reset then idle: after rst returns high, commit_ready_o = 1, count_o = 0, free_valid_o = 0 for 10 cycles.
- Dual release: one cycle with lanes {5, 9} valid → free_valid_o with preg 5 in cycle t+1, preg 9 in cycle t+2, then free_valid_o = 0 and count_o = 0.
- p0 filtering: lanes {0, 7} valid → only 7 is emitted, count_o peaks at 1, overflow_o stays 0.
- Recovery hold: enqueue 12, assert recover_i for 3 cycles starting at t+1 → free_valid_o = 0 for those 3 cycles, then preg 12 emitted. No entry is lost.
- Fill and overflow (DEPTH = 16, COMMIT_W = 2, recover_i held high):
  - Push 2 per cycle for 8 cycles → count_o = 16 and commit_ready_o drops once count_o reaches 15.
  - Push once more → overflow_o = 1 and count_o unchanged.
  - Release recover_i → 16 frees emitted in FIFO order across pointer wrap.
- Asynchronous reset mid-stream: assert rst low between clock edges with count_o = 6 → count_o = 0 and free_valid_o = 0 without waiting for a clock edge.
